cp0: RTL and testbench
======================

CP0 -- requirements
Module: cp0

Interface
REQ-001 SHALL have parameter PRID_VAL, default 32'h4D495053, value returned by PRId read.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port clr  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port HWInt  input  6  hardware interrupt lines from bus bridge intr output, bit0 = timer 0.
REQ-005 SHALL have ports A1  input  5  read register number; A2  input  5  write register number.
REQ-006 SHALL have ports Din  input  32  mtc0 write data; WE  input  1  mtc0 write enable.
REQ-007 SHALL have ports PC  input  32  address of victim instruction; BD  input  1  victim is in branch delay slot.
REQ-008 SHALL have ports ExcReq  input  1  internal exception request; ExcCode  input  5  its cause code.
REQ-009 SHALL have port EXLClr  input  1  eret retiring this cycle.
REQ-010 SHALL have ports IntReq  output  1  take exception this cycle; EPC  output  32  EPC register; Dout  output  32  mfc0 read data.

Function
REQ-011 SHALL implement SR (reg 12) = IM[15:10], EXL[1], IE[0]; all other bits read 0.
REQ-012 SHALL implement Cause (reg 13) = BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
REQ-013 SHALL latch IP <= HWInt on every rising edge, unconditionally.
REQ-014 SHALL assert IntPend combinationally when |(HWInt & IM) && IE && !EXL (zero-cycle latency from HWInt).
REQ-015 SHALL drive IntReq = IntPend | (ExcReq && !EXL); interrupt has priority over internal exception.
REQ-016 SHALL, on edge with IntReq=1: EXL<=1; BD<=BD input; EPC<={BD ? PC-4 : PC}[31:2],2'b00; ExcCode<= IntPend ? 0 : ExcCode input.
REQ-017 SHALL, on edge with EXLClr=1 and IntReq=0, clear EXL; IntReq=1 in same cycle wins (EXL stays 1).
REQ-018 SHALL, on edge with WE=1 and IntReq=0: A2=12 loads IM,EXL,IE from Din[15:10],[1],[0]; A2=14 loads EPC<={Din[31:2],2'b00}; other A2 ignored.
REQ-019 SHALL ignore WE completely in any cycle where IntReq=1 (instruction killed).
REQ-020 SHALL drive Dout combinationally: A1=12 SR, 13 Cause, 14 EPC, 15 PRID_VAL, otherwise 0.
REQ-021 SHALL treat EXL=1 as masking both interrupts and internal exceptions (no nesting).
REQ-022 SHALL have PC-4 computed modulo 2^32 (PC=0 with BD=1 gives EPC=32'hFFFFFFFC).

Reset
REQ-023 SHALL, while clr=0, immediately force IM=0, EXL=0, IE=0, IP=0, BD=0, ExcCode=0, EPC=0, independent of clk.
REQ-024 SHALL therefore hold IntReq=0 during and on first edge after reset release.
REQ-025 SHALL treat reset asserted mid-exception as aborting it; no EPC update from that cycle.

Configuration
REQ-026 SHALL use macro CP0_EXC_EN to compile internal exception support.
REQ-027 SHALL, with CP0_EXC_EN defined, behave per REQ-015/016 including ExcReq/ExcCode.
REQ-028 SHALL, without CP0_EXC_EN, ignore ExcReq and ExcCode; IntReq = IntPend; Cause.ExcCode always 0.

Verification
REQ-029 Reset: clr=0 mid-run with EXL=1, EPC=32'h3000 -> all regs 0 immediately, Dout(A1=12)=0, IntReq=0.
REQ-030 Interrupt: SR=32'h0000_0401, HWInt=6'b000001, PC=32'h3010, BD=0 -> IntReq=1 same cycle; next edge EPC=32'h3010, EXL=1, Cause=32'h0000_0400.
REQ-031 Delay slot: as REQ-030 with BD=1, PC=32'h3014 -> EPC=32'h3010, Cause[31]=1.
REQ-032 Masking: SR=32'h0000_0403 (EXL=1) or IM=0, HWInt=6'h3F -> IntReq=0, IP still reads 6'h3F next cycle.
REQ-033 Collision: WE=1, A2=14, Din=32'h4000 while IntReq=1, PC=32'h3020 -> EPC=32'h3020; eret cycle EXLClr=1 -> EXL=0.
REQ-034 Exception (CP0_EXC_EN): ExcReq=1, ExcCode=5'd4, HWInt=0, EXL=0 -> IntReq=1, Cause[6:2]=4; with HWInt masked-in also -> Cause[6:2]=0.

Source files
------------

// File: rtl/cp0.sv
// CP0: MIPS-style coprocessor 0 holding SR, Cause, EPC and PRId.
// Hardware interrupts have zero-cycle latency from HWInt to IntReq, and the
// exception entry, the eret EXL clear and the mtc0 writes all happen on the
// same clock edge.
// Optional feature: define CP0_EXC_EN to add internal exception requests
// (ExcReq/ExcCode). Without it those inputs are ignored and Cause.ExcCode is 0.
module cp0 #(
    parameter logic [31:0] PRID_VAL = 32'h4D495053
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [5:0]  HWInt,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] Din,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic        ExcReq,
    input  logic [4:0]  ExcCode,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] Dout
);

    // Architectural state
    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic [5:0]  r_ip;
    logic        r_bd;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;

    logic        w_int_pend;
    logic        w_exc_req;
    logic [4:0]  w_exc_code;
    logic [31:0] w_pc_adj;
    logic [31:0] w_sr;
    logic [31:0] w_cause;

    // An enabled, unmasked hardware line raises an interrupt unless EXL is set
    assign w_int_pend = (|(HWInt & r_im)) && r_ie && !r_exl;

`ifdef CP0_EXC_EN
    // Internal exceptions are also blocked by EXL (no nesting)
    assign w_exc_req  = ExcReq && !r_exl;
    // An interrupt takes priority, so its cause code is 0
    assign w_exc_code = w_int_pend ? 5'd0 : ExcCode;
    logic w_unused;
    assign w_unused   = &{1'b0, w_pc_adj[1:0]};
`else
    assign w_exc_req  = 1'b0;
    assign w_exc_code = 5'd0;
    logic w_unused;
    assign w_unused   = &{1'b0, ExcReq, ExcCode, w_pc_adj[1:0]};
`endif

    assign IntReq = w_int_pend | w_exc_req;

    // A victim in a delay slot restarts at the branch (wraps modulo 2^32)
    assign w_pc_adj = BD ? (PC - 32'd4) : PC;

    assign w_sr    = {16'd0, r_im, 8'd0, r_exl, r_ie};
    assign w_cause = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'd0};
    assign EPC     = r_epc;

    // mfc0 read mux
    always_comb begin
        Dout = 32'd0;
        case (A1)
            5'd12:   Dout = w_sr;
            5'd13:   Dout = w_cause;
            5'd14:   Dout = r_epc;
            5'd15:   Dout = PRID_VAL;
            default: Dout = 32'd0;
        endcase
    end

    // Exception entry, eret and mtc0 writes; exception entry kills the write
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_im      <= 6'd0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_ip      <= 6'd0;
            r_bd      <= 1'b0;
            r_exccode <= 5'd0;
            r_epc     <= 32'd0;
        end else begin
            r_ip <= HWInt;
            if (IntReq) begin
                r_exl     <= 1'b1;
                r_bd      <= BD;
                r_epc     <= {w_pc_adj[31:2], 2'b00};
                r_exccode <= w_exc_code;
            end else begin
                if (EXLClr) begin
                    r_exl <= 1'b0;
                end
                if (WE) begin
                    if (A2 == 5'd12) begin
                        r_im  <= Din[15:10];
                        r_exl <= Din[1];
                        r_ie  <= Din[0];
                    end else if (A2 == 5'd14) begin
                        r_epc <= {Din[31:2], 2'b00};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0.sv
// Testbench for cp0: a constant-expectation vector table, directed corner
// sequences, and randomized traffic checked every cycle against a word-level
// model of the CP0 registers.
module tb_cp0;

    logic        clk;
    logic        clr;
    logic [5:0]  HWInt;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] Din;
    logic        WE;
    logic [31:0] PC;
    logic        BD;
    logic        ExcReq;
    logic [4:0]  ExcCode;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] Dout;

    localparam logic [31:0] PRID = 32'h4D495053;

    int checks;
    int failures;

    cp0 #(.PRID_VAL(PRID)) dut (
        .clk(clk), .clr(clr), .HWInt(HWInt), .A1(A1), .A2(A2), .Din(Din),
        .WE(WE), .PC(PC), .BD(BD), .ExcReq(ExcReq), .ExcCode(ExcCode),
        .EXLClr(EXLClr), .IntReq(IntReq), .EPC(EPC), .Dout(Dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: SR, Cause and EPC kept as whole 32-bit register words
    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    function automatic logic m_int_pend();
        return ((({26'd0, HWInt} << 10) & m_sr) != 32'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_take();
`ifdef CP0_EXC_EN
        return m_int_pend() || (ExcReq && !m_sr[1]);
`else
        return m_int_pend();
`endif
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_sr    = 32'd0;
        m_cause = 32'd0;
        m_epc   = 32'd0;
    endtask

    // Advance the model across one rising edge using the inputs now applied
    task automatic m_edge();
        logic        pend;
        logic        take;
        logic [31:0] code;
        pend = m_int_pend();
        take = m_take();
        m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, HWInt} << 10);
        if (take) begin
            m_sr  = m_sr | 32'h2;
            m_epc = (PC - (BD ? 32'd4 : 32'd0)) & 32'hFFFF_FFFC;
`ifdef CP0_EXC_EN
            code = pend ? 32'd0 : {27'd0, ExcCode};
`else
            code = 32'd0;
`endif
            m_cause = (m_cause & 32'h0000_FC00) | ({31'd0, BD} << 31) | (code << 2);
        end else begin
            if (EXLClr) m_sr = m_sr & ~32'h2;
            if (WE && A2 == 5'd12) m_sr = Din & 32'h0000_FC03;
            if (WE && A2 == 5'd14) m_epc = Din & 32'hFFFF_FFFC;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] a2, input logic [31:0] din,
                         input logic [5:0] hw, input logic [31:0] pc, input logic bd,
                         input logic exlclr, input logic excreq, input logic [4:0] exccode,
                         input logic [4:0] a1);
        WE = we; A2 = a2; Din = din; HWInt = hw; PC = pc; BD = bd;
        EXLClr = exlclr; ExcReq = excreq; ExcCode = exccode; A1 = a1;
    endtask

    // One clock cycle, entered and left at posedge+1; model checks every
    // cycle, plus constant expectations when has_exp is set
    task automatic cycle(input bit has_exp, input logic exp_int, input logic [31:0] exp_dout,
                         input string name);
        #2;
        chk("model_intreq", {31'd0, IntReq}, {31'd0, m_take()});
        chk("model_dout", Dout, m_read(A1));
        chk("model_epc", EPC, m_epc);
        if (has_exp) begin
            chk({name, "_intreq"}, {31'd0, IntReq}, {31'd0, exp_int});
            chk({name, "_dout"}, Dout, exp_dout);
        end
        $display("cyc t=%0t A1=%0d HWInt=%02h IntReq=%0b Dout=%08h EPC=%08h",
                 $time, A1, HWInt, IntReq, Dout, EPC);
        @(posedge clk);
        m_edge();
        #1;
    endtask

    // Asynchronous reset between edges: everything must read 0 at once
    task automatic do_reset(input string name);
        A1 = 5'd12;
        clr = 1'b0;
        #1;
        m_reset();
        chk({name, "_rst_intreq"}, {31'd0, IntReq}, 32'd0);
        chk({name, "_rst_sr"}, Dout, 32'd0);
        chk({name, "_rst_epc"}, EPC, 32'd0);
        A1 = 5'd13;
        #1;
        chk({name, "_rst_cause"}, Dout, 32'd0);
        $display("reset %s IntReq=%0b EPC=%08h", name, IntReq, EPC);
        @(posedge clk);
        #1;
        clr = 1'b1;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  a2;
        logic [31:0] din;
        logic [5:0]  hw;
        logic [31:0] pc;
        logic        bd;
        logic        exlclr;
        logic [4:0]  a1;
        logic        exp_int;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{1'b0, 5'd0,  32'h0,         6'h00, 32'h0,    1'b0, 1'b0, 5'd12, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,         6'h00, 32'h0,    1'b0, 1'b0, 5'd15, 1'b0, PRID};
        tbl[2]  = '{1'b1, 5'd12, 32'hFFFF_FC01, 6'h00, 32'h0,    1'b0, 1'b0, 5'd12, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 5'd0,  32'h0,         6'h00, 32'h0,    1'b0, 1'b0, 5'd12, 1'b0, 32'h0000_FC01};
        tbl[4]  = '{1'b0, 5'd0,  32'h0,         6'h04, 32'h3010, 1'b0, 1'b0, 5'd13, 1'b1, 32'h0};
        tbl[5]  = '{1'b0, 5'd0,  32'h0,         6'h3F, 32'h0,    1'b0, 1'b0, 5'd14, 1'b0, 32'h0000_3010};
        tbl[6]  = '{1'b0, 5'd0,  32'h0,         6'h00, 32'h0,    1'b0, 1'b0, 5'd13, 1'b0, 32'h0000_FC00};
        tbl[7]  = '{1'b0, 5'd0,  32'h0,         6'h00, 32'h0,    1'b0, 1'b1, 5'd12, 1'b0, 32'h0000_FC03};
        tbl[8]  = '{1'b0, 5'd0,  32'h0,         6'h01, 32'h0,    1'b1, 1'b0, 5'd12, 1'b1, 32'h0000_FC01};
        tbl[9]  = '{1'b0, 5'd0,  32'h0,         6'h00, 32'h0,    1'b0, 1'b0, 5'd14, 1'b0, 32'hFFFF_FFFC};
        tbl[10] = '{1'b0, 5'd0,  32'h0,         6'h00, 32'h0,    1'b0, 1'b0, 5'd13, 1'b0, 32'h8000_0000};
        tbl[11] = '{1'b1, 5'd12, 32'h0000_0401, 6'h00, 32'h0,    1'b0, 1'b0, 5'd13, 1'b0, 32'h8000_0000};
        tbl[12] = '{1'b0, 5'd0,  32'h0,         6'h02, 32'h0,    1'b0, 1'b0, 5'd12, 1'b0, 32'h0000_0401};
        tbl[13] = '{1'b0, 5'd0,  32'h0,         6'h00, 32'h0,    1'b0, 1'b0, 5'd13, 1'b0, 32'h8000_0800};
        tbl[14] = '{1'b1, 5'd13, 32'hFFFF_FFFF, 6'h00, 32'h0,    1'b0, 1'b0, 5'd13, 1'b0, 32'h8000_0000};
        tbl[15] = '{1'b0, 5'd0,  32'h0,         6'h00, 32'h0,    1'b0, 1'b0, 5'd13, 1'b0, 32'h8000_0000};
    end

    initial begin
        checks   = 0;
        failures = 0;
        clr = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd12);
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b1;

        // Vector table, starting from the reset state
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].we, tbl[i].a2, tbl[i].din, tbl[i].hw, tbl[i].pc, tbl[i].bd,
                  tbl[i].exlclr, 1'b0, 5'd0, tbl[i].a1);
            cycle(1'b1, tbl[i].exp_int, tbl[i].exp_dout, $sformatf("vec%0d", i));
        end

        // Reset in the middle of an exception: EXL=1, EPC=0x3000, interrupt pending
        drive(1'b1, 5'd14, 32'h0000_3000, 6'h00, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd14);
        cycle(1'b0, 1'b0, 32'd0, "setepc");
        drive(1'b1, 5'd12, 32'h0000_0403, 6'h00, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd14);
        cycle(1'b1, 1'b0, 32'h0000_3000, "setexl");
        drive(1'b0, 5'd0, 32'h0, 6'h3F, 32'h5000, 1'b0, 1'b0, 1'b1, 5'd4, 5'd12);
        do_reset("midexc");
        drive(1'b0, 5'd0, 32'h0, 6'h3F, 32'h5000, 1'b0, 1'b0, 1'b0, 5'd0, 5'd14);
        cycle(1'b1, 1'b0, 32'h0, "post_rst");

        // Interrupt entry, non-delay-slot victim
        drive(1'b1, 5'd12, 32'h0000_0401, 6'h00, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd12);
        cycle(1'b1, 1'b0, 32'h0, "int_setsr");
        drive(1'b0, 5'd0, 32'h0, 6'h01, 32'h3010, 1'b0, 1'b0, 1'b0, 5'd0, 5'd12);
        cycle(1'b1, 1'b1, 32'h0000_0401, "int_req");
        drive(1'b0, 5'd0, 32'h0, 6'h00, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd13);
        cycle(1'b1, 1'b0, 32'h0000_0400, "int_cause");
        drive(1'b0, 5'd0, 32'h0, 6'h00, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd14);
        cycle(1'b1, 1'b0, 32'h0000_3010, "int_epc");
        drive(1'b0, 5'd0, 32'h0, 6'h00, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd12);
        cycle(1'b1, 1'b0, 32'h0000_0403, "int_eret");

        // Delay-slot victim
        drive(1'b0, 5'd0, 32'h0, 6'h01, 32'h3014, 1'b1, 1'b0, 1'b0, 5'd0, 5'd12);
        cycle(1'b1, 1'b1, 32'h0000_0401, "bd_req");
        drive(1'b0, 5'd0, 32'h0, 6'h00, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd13);
        cycle(1'b1, 1'b0, 32'h8000_0400, "bd_cause");
        drive(1'b0, 5'd0, 32'h0, 6'h00, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd14);
        cycle(1'b1, 1'b0, 32'h0000_3010, "bd_epc");

        // mtc0 EPC colliding with an interrupt: the write is killed
        drive(1'b1, 5'd14, 32'h0000_4000, 6'h01, 32'h3020, 1'b0, 1'b0, 1'b0, 5'd0, 5'd14);
        cycle(1'b1, 1'b1, 32'h0000_3010, "coll_req");
        drive(1'b0, 5'd0, 32'h0, 6'h00, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd14);
        cycle(1'b1, 1'b0, 32'h0000_3020, "coll_epc");
        drive(1'b0, 5'd0, 32'h0, 6'h00, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd12);
        cycle(1'b1, 1'b0, 32'h0000_0403, "coll_eret");
        drive(1'b0, 5'd0, 32'h0, 6'h00, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd12);
        cycle(1'b1, 1'b0, 32'h0000_0401, "coll_exl0");

        // Masking by EXL, then by IM=0; IP still tracks HWInt
        drive(1'b1, 5'd12, 32'h0000_0403, 6'h00, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd12);
        cycle(1'b1, 1'b0, 32'h0000_0401, "mask_setexl");
        drive(1'b0, 5'd0, 32'h0, 6'h3F, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd12);
        cycle(1'b1, 1'b0, 32'h0000_0403, "mask_exl");
        drive(1'b0, 5'd0, 32'h0, 6'h00, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd13);
        cycle(1'b1, 1'b0, 32'h0000_FC00, "mask_ip1");
        drive(1'b1, 5'd12, 32'h0000_0001, 6'h00, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd13);
        cycle(1'b1, 1'b0, 32'h0, "mask_setim0");
        drive(1'b0, 5'd0, 32'h0, 6'h3F, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd12);
        cycle(1'b1, 1'b0, 32'h0000_0001, "mask_im0");
        drive(1'b0, 5'd0, 32'h0, 6'h00, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd13);
        cycle(1'b1, 1'b0, 32'h0000_FC00, "mask_ip2");

        // Internal exception, alone and together with an interrupt
        drive(1'b0, 5'd0, 32'h0, 6'h00, 32'h0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd12);
`ifdef CP0_EXC_EN
        cycle(1'b1, 1'b1, 32'h0000_0001, "exc_req");
        drive(1'b0, 5'd0, 32'h0, 6'h00, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd13);
        cycle(1'b1, 1'b0, 32'h0000_0010, "exc_cause");
        drive(1'b0, 5'd0, 32'h0, 6'h00, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd12);
        cycle(1'b1, 1'b0, 32'h0000_0003, "exc_eret");
`else
        cycle(1'b1, 1'b0, 32'h0000_0001, "exc_req");
        drive(1'b0, 5'd0, 32'h0, 6'h00, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd13);
        cycle(1'b1, 1'b0, 32'h0, "exc_cause");
        drive(1'b0, 5'd0, 32'h0, 6'h00, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd12);
        cycle(1'b1, 1'b0, 32'h0000_0001, "exc_eret");
`endif
        drive(1'b1, 5'd12, 32'h0000_0401, 6'h00, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd12);
        cycle(1'b1, 1'b0, 32'h0000_0001, "exc_setsr");
        drive(1'b0, 5'd0, 32'h0, 6'h01, 32'h3030, 1'b0, 1'b0, 1'b1, 5'd4, 5'd12);
        cycle(1'b1, 1'b1, 32'h0000_0401, "exc_both");
        drive(1'b0, 5'd0, 32'h0, 6'h00, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd13);
        cycle(1'b1, 1'b0, 32'h0000_0400, "exc_both_cause");
        drive(1'b0, 5'd0, 32'h0, 6'h00, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd12);
        cycle(1'b1, 1'b0, 32'h0000_0403, "exc_both_eret");

        // Randomized traffic against the model, with occasional async resets
        for (int n = 0; n < 600; n++) begin
            logic        r_we;
            logic [4:0]  r_a2;
            logic [31:0] r_din;
            logic        r_clrexl;
            logic [2:0]  sel;
            sel   = 3'($urandom_range(0, 7));
            r_we  = ($urandom_range(0, 3) == 0);
            r_a2  = (sel < 3) ? 5'd12 : (sel < 5) ? 5'd14 : 5'($urandom_range(0, 31));
            r_din = $urandom;
            if (r_a2 == 5'd12 && $urandom_range(0, 3) != 0) r_din[1:0] = 2'b01;
            r_clrexl = ($urandom_range(0, 4) == 0);
            if (r_we && r_a2 == 5'd12) r_clrexl = 1'b0;
            drive(r_we, r_a2, r_din,
                  ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(0, 63)),
                  $urandom, 1'($urandom_range(0, 1)), r_clrexl,
                  ($urandom_range(0, 5) == 0), 5'($urandom_range(0, 31)),
                  5'($urandom_range(10, 16)));
            if ($urandom_range(0, 79) == 0) begin
                do_reset("rand");
            end
            cycle(1'b0, 1'b0, 32'd0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
